// File: rtl/mips_pkg.sv
// Shared types for the MIPS multiply/divide unit: operation codes and FSM states.
package mips_pkg;

  typedef enum logic [2:0] {
    NOP   = 3'd0,
    MULT  = 3'd1,
    MULTU = 3'd2,
    DIV   = 3'd3,
    DIVU  = 3'd4,
    MTHI  = 3'd5,
    MTLO  = 3'd6
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/mips_muldiv_if.sv
// Request/result bundle between the execute-stage control and the mul/div unit.
interface mips_muldiv_if
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             start;
  muldiv_op_t       op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, src1, src2, flush, input busy, done, hi, lo);
  modport slave  (input start, op, src1, src2, flush, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate; gives |a| when neg is the sign bit of a.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);
  assign y = neg ? (~a + W'(1)) : a;
endmodule

// File: rtl/mips_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers: one result bit per cycle,
// followed by a single sign-correction cycle.
module mips_muldiv
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  mips_muldiv_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  muldiv_state_t      state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               busy_reg, done_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic [WIDTH-1:0]   mcand_reg;   // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_reg;     // product accumulator; low half holds quotient when dividing
  logic [WIDTH-1:0]   rem_reg;
  logic               is_div_reg, divz_reg, neg_lo_reg, neg_hi_reg;

  // Operand magnitudes, taken combinationally from the request so they latch at start.
  logic                  is_signed, load_div;
  logic [1:0][WIDTH-1:0] src_raw, src_mag;
  logic [1:0]            src_neg;

  assign is_signed = (bus.op == MULT) || (bus.op == DIV);
  assign load_div  = (bus.op == DIV)  || (bus.op == DIVU);
  assign src_raw   = {bus.src2, bus.src1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_abs
      assign src_neg[gi] = is_signed & src_raw[gi][WIDTH-1];
      muldiv_sign_fix #(.W(WIDTH)) u_abs (
        .a(src_raw[gi]), .neg(src_neg[gi]), .y(src_mag[gi])
      );
    end
  endgenerate

  // Shift-add step: conditionally add the multiplicand into the upper half, then shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
  assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

  // Restoring step on a WIDTH+1-bit partial remainder; the stored remainder always fits WIDTH bits.
  logic [WIDTH:0]   div_shift, div_trial;
  logic             div_ok;
  logic [WIDTH-1:0] rem_next, quo_next;
  assign div_shift = {rem_reg, acc_reg[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, mcand_reg};
  assign div_ok    = ~div_trial[WIDTH];
  assign rem_next  = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign quo_next  = {acc_reg[WIDTH-2:0], div_ok};

  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed, rem_fixed;

  muldiv_sign_fix #(.W(2*WIDTH)) u_prod_fix (.a(acc_reg), .neg(neg_lo_reg), .y(prod_fixed));
  muldiv_sign_fix #(.W(WIDTH)) u_quo_fix (.a(acc_reg[WIDTH-1:0]), .neg(neg_lo_reg), .y(quo_fixed));
  muldiv_sign_fix #(.W(WIDTH)) u_rem_fix (.a(rem_reg), .neg(neg_hi_reg), .y(rem_fixed));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      mcand_reg  <= '0;
      acc_reg    <= '0;
      rem_reg    <= '0;
      is_div_reg <= 1'b0;
      divz_reg   <= 1'b0;
      neg_lo_reg <= 1'b0;
      neg_hi_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            case (bus.op)
              MTHI: hi_reg <= bus.src1;
              MTLO: lo_reg <= bus.src1;
              MULT, MULTU, DIV, DIVU: begin
                mcand_reg  <= load_div ? src_mag[1] : src_mag[0];
                acc_reg    <= {{WIDTH{1'b0}}, (load_div ? src_mag[0] : src_mag[1])};
                rem_reg    <= '0;
                is_div_reg <= load_div;
                divz_reg   <= (bus.src2 == '0);
                neg_lo_reg <= src_neg[0] ^ src_neg[1];
                neg_hi_reg <= src_neg[0];
                cnt_reg    <= '0;
                busy_reg   <= 1'b1;
                state_reg  <= RUN;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          if (bus.flush) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            if (is_div_reg) begin
              rem_reg             <= rem_next;
              acc_reg[WIDTH-1:0]  <= quo_next;
            end else begin
              acc_reg <= mul_next;
            end
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_W'(WIDTH - 1)) state_reg <= SIGN;
          end
        end
        SIGN: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
          if (!bus.flush) begin
            done_reg <= 1'b1;
            if (is_div_reg) begin
              lo_reg <= divz_reg ? '1 : quo_fixed;
              hi_reg <= rem_fixed;
            end else begin
              {hi_reg, lo_reg} <= prod_fixed;
            end
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;
endmodule
